// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame shape constants and
// the bit-period helper used by the transmitter.
package uart_pkg;

  // Line FSM states; the encoding is visible on state_out_dbg.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 8N1 frame: eight data bits, one stop bit, no parity.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // clk cycles per line bit (integer division truncates).
  function automatic int cyc_count(input int system_clock, input int baud_rate);
    return system_clock / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CYC_COUNT-1 and flags the last cycle of
// each bit slot. Held at zero while i_restart is high so a new frame
// always begins on a fresh bit boundary.
module uart_baud_gen #(
  parameter int CYC_COUNT = 3333
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int W = (CYC_COUNT < 2) ? 1 : $clog2(CYC_COUNT);
  localparam logic [W-1:0] LAST = W'(CYC_COUNT - 1);

  logic [W-1:0] r_cnt;

  // A divider shorter than two cycles cannot time a bit slot.
  generate
    if (CYC_COUNT < 2) begin : g_bad_cyc_count
      $error("uart_baud_gen: CYC_COUNT must be at least 2");
    end
  endgenerate

  // Free-running modulo-CYC_COUNT counter, cleared on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A request accepted in IDLE latches the byte and
// the frame then runs to completion independent of en/data_in.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 32000000,
  parameter int BAUD_RATE    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic       rdy,
  output logic       dout,
  output logic [1:0] state_out_dbg
);

  localparam int CYC_COUNT = cyc_count(SYSTEM_CLOCK, BAUD_RATE);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t r_state, w_state_next;
  logic [7:0]  r_shift, w_shift_next;
  logic [2:0]  r_bit_cnt, w_bit_cnt_next;
  logic        r_dout, w_dout_next;
  logic        w_tick;
  logic        w_restart;

  // Divider sits at zero while idle so START gets a full bit period.
  assign w_restart = (r_state == IDLE);

  uart_baud_gen #(
    .CYC_COUNT (CYC_COUNT)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // State, shift register, bit counter and line output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_dout    <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_dout    <= w_dout_next;
    end
  end

  // Next-state logic; the line value is computed for the state being
  // entered so dout changes exactly on the slot boundary.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_dout_next    = r_dout;
    unique case (r_state)
      IDLE: begin
        w_dout_next = 1'b1;
        if (en) begin
          w_shift_next   = data_in;
          w_bit_cnt_next = '0;
          w_state_next   = START;
          w_dout_next    = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
          w_dout_next  = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_DATA) begin
            w_state_next   = STOP;
            w_bit_cnt_next = '0;
            w_dout_next    = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            w_shift_next   = r_shift >> 1;
            w_dout_next    = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_STOP) begin
            w_state_next = IDLE;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
          w_dout_next = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_dout_next  = 1'b1;
      end
    endcase
  end

  assign dout          = r_dout;
  assign rdy           = (r_state == IDLE);
  assign state_out_dbg = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level reference model checked every cycle,
// plus literal bit patterns and durations for the directed cases.
module tb_uart_tx;

  // 50/7 truncates to 7 cycles per bit.
  localparam int C     = 7;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rdy, dout;
  logic [1:0] state_out_dbg;

  logic       en2 = 1'b0;
  logic [7:0] data2 = 8'h5A;
  logic       rdy2, dout2;
  logic [1:0] state2;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  uart_tx #(.SYSTEM_CLOCK(50), .BAUD_RATE(7)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .rdy(rdy), .dout(dout), .state_out_dbg(state_out_dbg)
  );

  uart_tx #(.SYSTEM_CLOCK(100000000), .BAUD_RATE(115200)) dut_fast (
    .clk(clk), .rst(rst), .en(en2), .data_in(data2),
    .rdy(rdy2), .dout(dout2), .state_out_dbg(state2)
  );

  // ---------------- reference model ----------------
  // A frame is a 10-slot word {stop, data, start}; while active, the
  // position within the frame selects the slot as pos / C.
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [9:0] m_frame = '1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_pos    <= 0;
    end else if (!m_active) begin
      if (en) begin
        m_active <= 1'b1;
        m_pos    <= 0;
        m_frame  <= {1'b1, data_in, 1'b0};
      end
    end else if (m_pos == FRAME - 1) begin
      m_active <= 1'b0;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  logic       exp_dout, exp_rdy;
  logic [1:0] exp_state;
  int         exp_slot;

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_slot  = m_pos / C;
      exp_dout  = m_active ? m_frame[exp_slot] : 1'b1;
      exp_rdy   = !m_active;
      exp_state = !m_active ? 2'd0 : (exp_slot == 0) ? 2'd1 : (exp_slot <= 8) ? 2'd2 : 2'd3;
      n_checks++;
      if (dout !== exp_dout || rdy !== exp_rdy || state_out_dbg !== exp_state) begin
        n_fails++;
        $display("FAIL cycle_model t=%0t dout=%b exp=%b rdy=%b exp=%b state=%0d exp=%0d",
                 $time, dout, exp_dout, rdy, exp_rdy, state_out_dbg, exp_state);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Waits for the next frame, samples mid-slot, and returns at the first
  // idle negedge. idle_before counts idle negedges seen before the frame.
  task automatic capture(output logic [9:0] bits, output int len, output int idle_before);
    int guard;
    bits = '0; len = 0; idle_before = 0; guard = 0;
    @(negedge clk);
    while (state_out_dbg == 2'd0 && guard < 200) begin
      idle_before++; guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_checks++; n_fails++;
      $display("FAIL capture_timeout actual=no_frame expected=frame_start");
    end else begin
      while (state_out_dbg != 2'd0 && len < 20 * C) begin
        if ((len % C) == C / 2 && (len / C) < 10) bits[len / C] = dout;
        len++;
        @(negedge clk);
      end
    end
  endtask

  logic [9:0] bits, bits2;
  int         len, len2, idle_b, extra, en_len;
  logic [7:0] d;

  initial begin
    // Reset held: outputs at idle values.
    @(negedge clk);
    check("reset_dout", dout, 1);
    check("reset_rdy", rdy, 1);
    check("reset_state", state_out_dbg, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Idle with en=0: the model check covers these cycles.
    repeat (20) @(negedge clk);
    check("idle_state", state_out_dbg, 0);

    // 0x55 with en held 10 cycles: exactly one frame.
    en = 1'b1; data_in = 8'h55;
    fork
      begin repeat (10) @(negedge clk); en = 1'b0; end
      capture(bits, len, idle_b);
    join
    check("f55_bits", bits, 10'b1010101010);
    check("f55_len", len, FRAME);
    extra = 0;
    repeat (3 * C) begin @(negedge clk); if (state_out_dbg != 2'd0) extra++; end
    check("f55_single_frame", extra, 0);
    $display("frame data=55 len=%0d bits=%b", len, bits);

    // 0xA3 with en held: back-to-back frames, one idle cycle between.
    en = 1'b1; data_in = 8'hA3;
    capture(bits, len, idle_b);
    capture(bits2, len2, idle_b);
    en = 1'b0;
    check("fA3_bits_1", bits, 10'b1101000110);
    check("fA3_bits_2", bits2, 10'b1101000110);
    check("fA3_len", len2, FRAME);
    check("fA3_idle_gap", idle_b, 0);
    $display("frame data=A3 back-to-back bits=%b/%b", bits, bits2);
    repeat (5) @(negedge clk);

    // 0x0F, data_in changed to 0xF0 mid-frame.
    en = 1'b1; data_in = 8'h0F;
    fork
      begin @(negedge clk); en = 1'b0; repeat (20) @(negedge clk); data_in = 8'hF0; end
      capture(bits, len, idle_b);
    join
    check("f0F_bits", bits, 10'b1000011110);
    $display("frame data=0F (changed mid-frame) bits=%b", bits);

    // Randomized frames with scrambled data_in during transmission.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      d = 8'($urandom);
      en_len = $urandom_range(1, 4);
      en = 1'b1; data_in = d;
      fork
        begin
          for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            data_in = 8'($urandom);
            if (k == en_len - 1) en = 1'b0;
          end
        end
        capture(bits, len, idle_b);
      join
      check("rand_len", len, FRAME);
      $display("frame %0d data=%h len=%0d bits=%b", i, d, len, bits);
    end

    // Reset asserted during data bit 4.
    repeat (3) @(negedge clk);
    en = 1'b1; data_in = 8'hC5;
    @(negedge clk);
    en = 1'b0;
    repeat (5 * C + 2) @(negedge clk);
    check("pre_reset_state", state_out_dbg, 2);
    rst = 1'b1;
    #1;
    check("async_rst_dout", dout, 1);
    check("async_rst_rdy", rdy, 1);
    check("async_rst_state", state_out_dbg, 0);
    #1 rst = 1'b0;
    repeat (3 * C) @(negedge clk);
    check("post_reset_idle", state_out_dbg, 0);
    en = 1'b1; data_in = 8'h3C;
    fork
      begin @(negedge clk); en = 1'b0; end
      capture(bits, len, idle_b);
    join
    check("f3C_bits", bits, 10'b1001111000);
    check("f3C_len", len, FRAME);
    $display("frame data=3C after reset bits=%b", bits);

    // 100 MHz / 115200: 868 cycles per bit, 8680 per frame.
    @(negedge clk);
    en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    len = 0; len2 = 0;
    while (state2 != 2'd0 && len < 10000) begin
      if (state2 == 2'd1) len2++;
      len++;
      @(negedge clk);
    end
    check("fast_start_len", len2, 868);
    check("fast_frame_len", len, 8680);
    $display("frame fast data=5A len=%0d start=%0d", len, len2);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
